ps2_rx_port: RTL and testbench
==============================

Name: ps2_rx_port

Overview:
- Upstream stage of the CPU's keyboard path.
- Samples the raw PS/2 clock/data lines from the keyboard and decodes 11-bit device-to-host frames.
- Buffers received scan-code bytes in a small FIFO.
- Exposes the bytes to the PicoBlaze through two 8-bit I/O ports: data and status/control.

Parameters:
- FILTER_LEN, 4: consecutive identical samples required before a ps2_clk level change is accepted.
- TIMEOUT, 50000: idle clk cycles inside a frame before it is aborted (1 ms at 50 MHz).
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 bytes.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  port access strobe; already qualified by the top-level decode.
- wr  in  1  1 = write, 0 = read; valid while en is high.
- addr  in  1  0 = data port, 1 = status/control port.
- data_in  in  8  write data.
- data_out  out  8  read data (combinational from addr and FIFO head).
- irq  out  1  high while the FIFO is non-empty; registered.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers, count, sticky flags, bit counter and shift register go to 0.
  - FSM goes to IDLE; irq=0.
  - Synchronizers preset to 1 (idle bus).
  - reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchronizer.
  - Filtered clock changes state only after FILTER_LEN equal consecutive synchronized samples.
  - A falling edge of the filtered clock produces a one-cycle fall pulse, and ps2_data is sampled in that cycle.
  - Glitches shorter than FILTER_LEN cycles produce no pulse.
- FSM (advances on fall pulses):
  - IDLE: data=0 -> go to DATA, bitcnt=0. data=1 -> stay in IDLE (spurious start).
  - DATA: shift LSB first into shreg[7:0]; after 8 bits go to PARITY.
  - PARITY: latch the bit. Parity is odd: XOR of data bits and parity bit must be 1. Go to STOP.
  - STOP:
    - stop=1 and parity ok -> push byte into FIFO, go to IDLE.
    - parity bad -> set perr sticky, no push, go to IDLE.
    - stop=0 -> set ferr sticky, no push, go to IDLE.
  - Timeout counter clears on every fall pulse and counts while not in IDLE. Reaching TIMEOUT-1 forces IDLE with no flag and no push.
- FIFO:
  - Push happens in the cycle after STOP validation.
  - Push while full (and no pop that cycle) drops the new byte and sets ovf sticky; stored contents are unchanged.
  - Pop and push in the same cycle when full: both take effect, count unchanged, no ovf.
  - Pointers wrap modulo depth; count width is FIFO_AW+1.
- CPU read, addr 0:
  - data_out = FIFO head, or 0x00 if empty.
  - A pop happens at the clk edge where en & ~wr & addr==0 and the FIFO is non-empty.
  - Reading when empty changes nothing.
- CPU read, addr 1: data_out = {3'b0, ferr, perr, ovf, full, nonempty}.
- CPU write, addr 1: data_in bits [4:2] set to 1 clear ferr/perr/ovf respectively.
  - If a set event occurs in the same cycle as a clear, the set wins.
- Writes to addr 0: ignored.
- irq = registered nonempty; 1-cycle latency after the push or pop.

Decomposition:
- Shared package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Status bit index constants (ST_NEMPTY=0, ST_FULL=1, ST_OVF=2, ST_PERR=3, ST_FERR=4).
  - Port address constants (PORT_DATA=0, PORT_STAT=1).
- One sub-module, byte_fifo:
  - Parameterized FIFO_AW; synchronous push/pop.
  - Outputs: head, full, empty.
  - Same clk/reset convention (asynchronous, active-low).
- Filter, FSM and register file stay in ps2_rx_port.

Test Plan:
- Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1; ~12 kHz clock) -> status reads 0x01, irq=1; data read returns 0x1C, then status 0x00 and irq=0.
- Frame 0xF0 with parity bit 1 (wrong) -> no push, status 0x08. Write 0x08 to addr 1 -> status 0x00.
- Send 9 valid frames 0x01..0x09 with no reads -> status 0x07 (nonempty, full, ovf). Eight data reads return 0x01..0x08; a ninth read returns 0x00.
- Send start bit plus 4 data bits, then idle longer than TIMEOUT; then a valid frame 0x5A -> only 0x5A is stored, no error flags.
- 2-cycle low glitch on ps2_clk during IDLE and during DATA -> no bit consumed; the following frame 0x33 decodes correctly.
- Assert reset for 3 cycles mid-DATA with 2 bytes already in the FIFO -> status 0x00, irq=0; next frame 0x76 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive port: FSM states, status bits, port map.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int unsigned ST_NEMPTY = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_OVF    = 2;
    localparam int unsigned ST_PERR   = 3;
    localparam int unsigned ST_FERR   = 4;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_STAT = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; a push while full is accepted only if a pop happens in the same cycle.
module byte_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_din,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (FIFO_AW+1)'(DEPTH));
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wptr] <= i_din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_port.sv
// PS/2 device-to-host receiver with byte FIFO and a two-register CPU I/O port.
module ps2_rx_port
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    input  logic       ps2_clk,
    input  logic       ps2_data
);

    localparam int unsigned FC_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic            r_clk_filt, r_clk_filt_d;
    logic [FC_W-1:0] r_filt_cnt;
    logic            w_fall;

    ps2_state_t      r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shreg;
    logic            r_par;
    logic [TO_W-1:0] r_tocnt;
    logic            r_push_pend, r_perr_set, r_ferr_set;

    logic            r_ferr, r_perr, r_ovf;
    logic            r_irq;
    logic [2:0]      w_clr;
    logic            w_pop;
    logic [7:0]      w_head;
    logic            w_full, w_empty;
    logic [7:0]      w_status;
    logic            w_unused;

    assign w_unused = &{1'b0, data_in[7:5], data_in[1:0]};

    // Two-flop synchronizers, preset to the idle-high bus level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Clock deglitch: accept a new level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FC_MAX) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // Frame decoder advancing on filtered falling edges, with inactivity timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shreg     <= '0;
            r_par       <= 1'b0;
            r_tocnt     <= '0;
            r_push_pend <= 1'b0;
            r_perr_set  <= 1'b0;
            r_ferr_set  <= 1'b0;
        end else begin
            r_push_pend <= 1'b0;
            r_perr_set  <= 1'b0;
            r_ferr_set  <= 1'b0;
            if (w_fall) begin
                r_tocnt <= '0;
                case (r_state)
                    IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shreg  <= {r_dat_s2, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!r_dat_s2)
                            r_ferr_set <= 1'b1;
                        else if (!(^{r_shreg, r_par}))
                            r_perr_set <= 1'b1;
                        else
                            r_push_pend <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state == IDLE) begin
                r_tocnt <= '0;
            end else if (r_tocnt == TO_MAX) begin
                r_state <= IDLE;
                r_tocnt <= '0;
            end else begin
                r_tocnt <= r_tocnt + 1'b1;
            end
        end
    end

    assign w_pop = en & ~wr & (addr == PORT_DATA) & ~w_empty;
    assign w_clr = (en & wr & (addr == PORT_STAT)) ? data_in[4:2] : '0;

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (r_push_pend),
        .i_pop   (w_pop),
        .i_din   (r_shreg),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sticky error flags; a set event in the same cycle as a CPU clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_ferr <= (r_ferr & ~w_clr[2]) | r_ferr_set;
            r_perr <= (r_perr & ~w_clr[1]) | r_perr_set;
            r_ovf  <= (r_ovf  & ~w_clr[0]) | (r_push_pend & w_full & ~w_pop);
            r_irq  <= ~w_empty;
        end
    end

    assign irq = r_irq;

    // CPU read mux
    always_comb begin
        w_status            = '0;
        w_status[ST_NEMPTY] = ~w_empty;
        w_status[ST_FULL]   = w_full;
        w_status[ST_OVF]    = r_ovf;
        w_status[ST_PERR]   = r_perr;
        w_status[ST_FERR]   = r_ferr;
        if (addr == PORT_STAT)
            data_out = w_status;
        else
            data_out = w_empty ? 8'h00 : w_head;
    end

endmodule

// File: tb/tb_ps2_rx_port.sv
// Randomized self-checking bench for ps2_rx_port with a queue-based reference model.
module tb_ps2_rx_port;

    localparam int unsigned FILT = 4;
    localparam int unsigned TOUT = 200;
    localparam int unsigned H    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, wr = 1'b0, addr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       irq;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q[$];
    logic       m_ferr = 1'b0, m_perr = 1'b0, m_ovf = 1'b0;

    ps2_rx_port #(
        .FILTER_LEN (FILT),
        .TIMEOUT    (TOUT),
        .FIFO_AW    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_status();
        return {3'b000, m_ferr, m_perr, m_ovf, (m_q.size() == 8), (m_q.size() != 0)};
    endfunction

    function automatic void m_frame(input logic [7:0] b, input bit pbad, input bit sbad);
        if (sbad)                 m_ferr = 1'b1;
        else if (pbad)            m_perr = 1'b1;
        else if (m_q.size() == 8) m_ovf  = 1'b1;
        else                      m_q.push_back(b);
    endfunction

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
    endtask

    // One PS/2 bit cell: data set while clock high, then clock low half-period
    task automatic send_bit(input logic b, input bit do_glitch);
        ps2_data = b;
        if (do_glitch) begin
            wait_cyc(H / 2);
            glitch();
            wait_cyc(H / 2);
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pbad, input bit sbad, input int glitch_at);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ pbad;
        f[10]  = ~sbad;
        for (int i = 0; i < 11; i++)
            send_bit(f[i], glitch_at == i);
        ps2_data = 1'b1;
        wait_cyc(H);
        m_frame(b, pbad, sbad);
    endtask

    task automatic read_data();
        logic [7:0] exp;
        exp  = (m_q.size() != 0) ? m_q[0] : 8'h00;
        en   = 1'b1; wr = 1'b0; addr = 1'b0;
        #1;
        check("data_rd", data_out, exp);
        wait_cyc(1);
        en = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic read_stat();
        en = 1'b1; wr = 1'b0; addr = 1'b1;
        #1;
        check("status_rd", data_out, m_status());
        wait_cyc(1);
        en = 1'b0;
    endtask

    task automatic write_stat(input logic [7:0] v);
        en = 1'b1; wr = 1'b1; addr = 1'b1; data_in = v;
        wait_cyc(1);
        en = 1'b0; wr = 1'b0;
        if (v[4]) m_ferr = 1'b0;
        if (v[3]) m_perr = 1'b0;
        if (v[2]) m_ovf  = 1'b0;
    endtask

    task automatic check_irq();
        wait_cyc(2);
        check("irq", {7'b0, irq}, {7'b0, (m_q.size() != 0)});
    endtask

    initial begin
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(2);
        read_stat();
        check_irq();
        read_data();

        // valid 0x1C
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        read_stat();
        check_irq();
        read_data();
        read_stat();
        check_irq();

        // 0xF0 with wrong parity, then clear perr
        send_frame(8'hF0, 1'b1, 1'b0, -1);
        read_stat();
        write_stat(8'h08);
        read_stat();

        // overflow: nine frames, nine reads
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 1'b0, 1'b0, -1);
        read_stat();
        for (int i = 0; i < 9; i++)
            read_data();
        read_stat();
        write_stat(8'h04);
        read_stat();

        // partial frame abandoned by timeout, then 0x5A
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'(i & 1), 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TOUT + 60);
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        read_stat();
        read_data();
        read_stat();

        // glitches in idle and mid-data
        glitch();
        wait_cyc(10);
        send_frame(8'h33, 1'b0, 1'b0, 4);
        read_stat();
        read_data();

        // reset mid-frame with two bytes queued
        send_frame(8'hA1, 1'b0, 1'b0, -1);
        send_frame(8'hB2, 1'b0, 1'b0, -1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        m_q.delete();
        m_ferr = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
        wait_cyc(2);
        read_stat();
        check_irq();
        send_frame(8'h76, 1'b0, 1'b0, -1);
        read_stat();
        read_data();
        check_irq();

        // randomized mix of traffic and CPU accesses
        for (int it = 0; it < 60; it++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
            end else if (op <= 6) begin
                read_data();
            end else if (op == 7) begin
                read_stat();
            end else if (op == 8) begin
                write_stat({3'b000, 3'($urandom), 2'b00});
                read_stat();
            end else begin
                check_irq();
            end
        end
        read_stat();
        while (m_q.size() != 0)
            read_data();
        read_data();
        check_irq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
